// File: rtl/dot_seq_sat_pkg.sv
// Shared types and default sizing for the sequential saturating dot-product block.
package dot_seq_sat_pkg;

  localparam int unsigned NumWidth   = 16;
  localparam int unsigned FracWidth  = 8;
  localparam int unsigned IndexWidth = 4;
  localparam int unsigned OutputSize = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/dot_seq_sat_if.sv
// Job request / result bundle between the weight storage side and the activation stage.
interface dot_seq_sat_if #(
  parameter int unsigned Len      = 3,
  parameter int unsigned NumWidth = 16
);

  logic                       start;
  logic                       abort;
  logic [Len*NumWidth-1:0]    a_pk;
  logic [Len*NumWidth-1:0]    w_pk;
  logic signed [NumWidth-1:0] bias;
  logic                       ready;
  logic                       busy;
  logic                       done;
  logic signed [NumWidth-1:0] result;

  modport master (
    output start, abort, a_pk, w_pk, bias,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, abort, a_pk, w_pk, bias,
    output ready, busy, done, result
  );

endinterface

// File: rtl/dot_seq_sat_mac.sv
// One saturating multiply-accumulate step: acc_next = add_sat(acc, mul_sat(a, w)).
module dot_seq_sat_mac #(
  parameter int unsigned NumWidth  = 16,
  parameter int unsigned FracWidth = 8
) (
  input  logic signed [NumWidth-1:0] acc,
  input  logic signed [NumWidth-1:0] a,
  input  logic signed [NumWidth-1:0] w,
  output logic signed [NumWidth-1:0] acc_next
);

  localparam logic signed [NumWidth-1:0] MaxVal = {1'b0, {(NumWidth-1){1'b1}}};
  localparam logic signed [NumWidth-1:0] MinVal = {1'b1, {(NumWidth-1){1'b0}}};

  logic [2*NumWidth-1:0]        a_ext;
  logic [2*NumWidth-1:0]        w_ext;
  logic signed [2*NumWidth-1:0] prod;
  logic signed [2*NumWidth-1:0] prod_shr;
  logic signed [NumWidth-1:0]   mul_res;
  logic [NumWidth:0]            sum;

  always_comb begin
    a_ext    = {{NumWidth{a[NumWidth-1]}}, a};
    w_ext    = {{NumWidth{w[NumWidth-1]}}, w};
    // Low 2*NumWidth bits of the unsigned product equal the signed product.
    prod     = a_ext * w_ext;
    prod_shr = prod >>> FracWidth;
    // In range only when the upper bits are a pure sign extension.
    if (&prod_shr[2*NumWidth-1:NumWidth-1] || ~|prod_shr[2*NumWidth-1:NumWidth-1]) begin
      mul_res = prod_shr[NumWidth-1:0];
    end else if (prod_shr[2*NumWidth-1]) begin
      mul_res = MinVal;
    end else begin
      mul_res = MaxVal;
    end

    sum = {acc[NumWidth-1], acc} + {mul_res[NumWidth-1], mul_res};
    if (sum[NumWidth] == sum[NumWidth-1]) begin
      acc_next = sum[NumWidth-1:0];
    end else if (sum[NumWidth]) begin
      acc_next = MinVal;
    end else begin
      acc_next = MaxVal;
    end
  end

endmodule

// File: rtl/dot_seq_sat.sv
// Sequential saturating dot product plus bias, one element per clock through a shared MAC.
module dot_seq_sat
  import dot_seq_sat_pkg::*;
#(
  parameter int unsigned Len        = OutputSize,
  parameter int unsigned NumWidth   = dot_seq_sat_pkg::NumWidth,
  parameter int unsigned FracWidth  = dot_seq_sat_pkg::FracWidth,
  parameter int unsigned IndexWidth = dot_seq_sat_pkg::IndexWidth
) (
  input  logic          clk,
  input  logic          rst_n,
  dot_seq_sat_if.slave  bus
);

  if (Len < 1 || Len > (2 ** IndexWidth)) begin : gen_len_check
    $error("Len must lie in [1, 2**IndexWidth]");
  end

  localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(Len - 1);

  state_e                     state_q, state_d;
  logic [Len*NumWidth-1:0]    a_q, a_d;
  logic [Len*NumWidth-1:0]    w_q, w_d;
  logic signed [NumWidth-1:0] acc_q, acc_d;
  logic signed [NumWidth-1:0] result_q, result_d;
  logic [IndexWidth-1:0]      idx_q, idx_d;

  logic signed [NumWidth-1:0] a_el;
  logic signed [NumWidth-1:0] w_el;
  logic signed [NumWidth-1:0] acc_next;

  assign a_el = a_q[int'(idx_q) * NumWidth +: NumWidth];
  assign w_el = w_q[int'(idx_q) * NumWidth +: NumWidth];

  dot_seq_sat_mac #(
    .NumWidth  (NumWidth),
    .FracWidth (FracWidth)
  ) u_mac (
    .acc      (acc_q),
    .a        (a_el),
    .w        (w_el),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    w_d      = w_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a_pk;
          w_d     = bus.w_pk;
          acc_d   = bus.bias;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Abort outranks the final-element transition.
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_next;
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            result_d = acc_next;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      w_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      w_q      <= w_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign bus.ready  = (state_q == StIdle);
  assign bus.busy   = (state_q == StRun);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule

// File: tb/tb_dot_seq_sat.sv
// Scoreboarded bench for dot_seq_sat: expected results queued at launch, checked on done.
module tb_dot_seq_sat;

  localparam int unsigned LEN = 3;
  localparam int unsigned NW  = 16;
  localparam int unsigned FW  = 8;
  localparam int ONE  = 1 << FW;
  localparam int MAXV = (1 << (NW - 1)) - 1;
  localparam int MINV = -(1 << (NW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_seq_sat_if #(.Len(LEN), .NumWidth(NW)) bus ();

  dot_seq_sat #(
    .Len        (LEN),
    .NumWidth   (NW),
    .FracWidth  (FW),
    .IndexWidth (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int done_count = 0;
  logic signed [NW-1:0] sb_q[$];

  function automatic logic [LEN*NW-1:0] pack3(input int e0, input int e1, input int e2);
    logic [LEN*NW-1:0] v;
    v[0*NW +: NW] = NW'(e0);
    v[1*NW +: NW] = NW'(e1);
    v[2*NW +: NW] = NW'(e2);
    return v;
  endfunction

  function automatic longint clamp(input longint x);
    if (x > MAXV) return longint'(MAXV);
    if (x < MINV) return longint'(MINV);
    return x;
  endfunction

  // Reference: saturate after every multiply and every add, elements in order 0..LEN-1.
  function automatic logic signed [NW-1:0] ref_dot(input logic [LEN*NW-1:0] a,
                                                   input logic [LEN*NW-1:0] w,
                                                   input logic signed [NW-1:0] b);
    longint acc;
    longint p;
    logic signed [NW-1:0] ae;
    logic signed [NW-1:0] we;
    acc = longint'(b);
    for (int i = 0; i < LEN; i++) begin
      ae  = a[i*NW +: NW];
      we  = w[i*NW +: NW];
      p   = longint'(ae) * longint'(we);
      p   = clamp(p >>> FW);
      acc = clamp(acc + p);
    end
    return acc[NW-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_count++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: result=%0d, no job outstanding", bus.result);
      end else begin
        logic signed [NW-1:0] exp_r;
        exp_r = sb_q.pop_front();
        if (bus.result !== exp_r) begin
          n_fail++;
          $display("FAIL sb_result: got %0d expected %0d", bus.result, exp_r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [LEN*NW-1:0] a, input logic [LEN*NW-1:0] w,
                        input logic signed [NW-1:0] b, input bit push);
    bus.a_pk  = a;
    bus.w_pk  = w;
    bus.bias  = b;
    bus.start = 1'b1;
    if (push) sb_q.push_back(ref_dot(a, w, b));
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20 && !bus.done; i++) step();
    n_cmp++;
    if (!bus.done) begin
      n_fail++;
      $display("FAIL %s_timeout: done=%0b expected 1 within 20 cycles", name, bus.done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100 || bus.result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy/busy/done=%b result=%0d expected 100 / 0",
               {bus.ready, bus.busy, bus.done}, bus.result);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    launch(pack3(ONE, 2 * ONE, 3 * ONE), pack3(ONE, ONE, ONE), '0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      n_cmp++;
      if ({bus.ready, bus.busy, bus.done} !== 3'b010) begin
        n_fail++;
        $display("FAIL basic_busy_T+%0d: rdy/busy/done=%b expected 010", k,
                 {bus.ready, bus.busy, bus.done});
      end
      step();
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.result !== NW'(6 * ONE)) begin
      n_fail++;
      $display("FAIL basic_done_T+4: done=%0b result=%0d expected 1 / %0d",
               bus.done, bus.result, 6 * ONE);
    end
    step();
    n_cmp++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_ready_T+5: rdy/busy/done=%b expected 100",
               {bus.ready, bus.busy, bus.done});
    end
  endtask

  task automatic test_negative();
    launch(pack3(-ONE, -ONE, -ONE), pack3(2 * ONE, 2 * ONE, 2 * ONE), NW'(-2 * ONE), 1'b1);
    bus.a_pk = {LEN{NW'($urandom)}};
    bus.w_pk = {LEN{NW'($urandom)}};
    bus.bias = NW'($urandom);
    wait_done("negative");
    n_cmp++;
    if (bus.result !== NW'(-8 * ONE)) begin
      n_fail++;
      $display("FAIL negative_result: got %0d expected %0d", bus.result, -8 * ONE);
    end
    step();
  endtask

  task automatic test_saturation();
    launch(pack3(MAXV, MAXV, -ONE), pack3(ONE, ONE, ONE), '0, 1'b1);
    wait_done("sat_step");
    n_cmp++;
    if (bus.result !== NW'(MAXV - ONE)) begin
      n_fail++;
      $display("FAIL sat_per_step: got %0d expected %0d", bus.result, MAXV - ONE);
    end
    step();
    launch(pack3(MINV, 0, 0), pack3(-ONE, 0, 0), '0, 1'b1);
    wait_done("sat_min");
    n_cmp++;
    if (bus.result !== NW'(MAXV)) begin
      n_fail++;
      $display("FAIL sat_min_times_neg1: got %0d expected %0d", bus.result, MAXV);
    end
    step();
    for (int j = 0; j < 6; j++) begin
      launch({LEN{NW'($urandom)}} ^ LEN*NW'($urandom), {LEN{NW'($urandom)}},
             NW'($urandom), 1'b1);
      wait_done("random");
      step();
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = done_count;
    bus.a_pk  = pack3(ONE, 2 * ONE, 3 * ONE);
    bus.w_pk  = pack3(ONE, ONE, ONE);
    bus.bias  = '0;
    bus.start = 1'b1;
    sb_q.push_back(ref_dot(bus.a_pk, bus.w_pk, bus.bias));
    step();
    step();
    step();
    step();
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_T+4: done=%0b expected 1", bus.done);
    end
    sb_q.push_back(ref_dot(bus.a_pk, bus.w_pk, bus.bias));
    step();
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_T+5: ready=%0b done=%0b expected 1 / 0", bus.ready, bus.done);
    end
    step();
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_start: busy=%0b expected 1", bus.busy);
    end
    bus.start = 1'b0;
    wait_done("b2b");
    step();
    // Start pulsed while busy must not queue a job.
    launch(pack3(ONE, ONE, ONE), pack3(ONE, ONE, ONE), '0, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("busy_start");
    step();
    step();
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || done_count - base != 3) begin
      n_fail++;
      $display("FAIL busy_start_ignored: ready=%0b busy=%0b dones=%0d expected 1 / 0 / 3",
               bus.ready, bus.busy, done_count - base);
    end
  endtask

  task automatic test_abort();
    int base;
    launch(pack3(ONE, 2 * ONE, 3 * ONE), pack3(ONE, ONE, ONE), '0, 1'b1);
    wait_done("abort_prior");
    step();
    base = done_count;
    launch(pack3(5 * ONE, 5 * ONE, 5 * ONE), pack3(ONE, ONE, ONE), '0, 1'b0);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== NW'(6 * ONE)) begin
      n_fail++;
      $display("FAIL abort_mid: ready=%0b busy=%0b result=%0d expected 1 / 0 / %0d",
               bus.ready, bus.busy, bus.result, 6 * ONE);
    end
    launch(pack3(5 * ONE, 5 * ONE, 5 * ONE), pack3(ONE, ONE, ONE), '0, 1'b0);
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.result !== NW'(6 * ONE)) begin
      n_fail++;
      $display("FAIL abort_last: done=%0b ready=%0b result=%0d expected 0 / 1 / %0d",
               bus.done, bus.ready, bus.result, 6 * ONE);
    end
    for (int k = 0; k < 4; k++) step();
    n_cmp++;
    if (done_count != base) begin
      n_fail++;
      $display("FAIL abort_no_done: dones=%0d expected %0d", done_count, base);
    end
    // Start and abort together in IDLE: start wins.
    bus.abort = 1'b1;
    launch(pack3(ONE, ONE, 0), pack3(ONE, ONE, 0), NW'(ONE), 1'b1);
    bus.abort = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_beats_abort: busy=%0b expected 1", bus.busy);
    end
    wait_done("start_abort");
    step();
  endtask

  task automatic test_reset_mid_run();
    launch(pack3(ONE, ONE, ONE), pack3(ONE, ONE, ONE), '0, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (bus.result !== '0 || {bus.ready, bus.busy, bus.done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_mid_run: result=%0d rdy/busy/done=%b expected 0 / 100",
               bus.result, {bus.ready, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    step();
    launch(pack3(2 * ONE, ONE, -ONE), pack3(ONE, 3 * ONE, ONE), NW'(ONE / 2), 1'b1);
    wait_done("after_reset");
    n_cmp++;
    if (bus.result !== NW'(4 * ONE + ONE / 2)) begin
      n_fail++;
      $display("FAIL after_reset_result: got %0d expected %0d", bus.result, 4 * ONE + ONE / 2);
    end
    step();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a_pk  = '0;
    bus.w_pk  = '0;
    bus.bias  = '0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d results outstanding, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
